// File: rtl/spi_slave.sv
// spi_slave: SPI slave (modes 0..3) clocked entirely by clk, with SCLK/CS_n/MOSI
//   taken through 2-flop synchronizers and a one-byte TX holding register.
//   Params : SPI_MODE (CPOL=SPI_MODE[1], CPHA=SPI_MODE[0]), DEFAULT_TX (sent when nothing is queued)
//   Ports  : clk, rst (async, active-high)
//            i_TX_Byte/i_TX_DV -> holding register, o_TX_Ready = holding register empty
//            o_RX_DV/o_RX_Byte  <- one-cycle strobe per received byte
//            i_SPI_Clk, i_SPI_CS_n, i_SPI_MOSI, o_SPI_MISO
//   Macro  : SPI_SLAVE_MISO_TRISTATE_EN -> o_SPI_MISO is Z in IDLE/reset instead of 0
module spi_slave #(
    parameter logic [1:0] SPI_MODE   = 2'd0,
    parameter logic [7:0] DEFAULT_TX = 8'h00
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] i_TX_Byte,
    input  logic       i_TX_DV,
    output logic       o_TX_Ready,
    output logic       o_RX_DV,
    output logic [7:0] o_RX_Byte,
    input  logic       i_SPI_Clk,
    input  logic       i_SPI_CS_n,
    input  logic       i_SPI_MOSI,
    output logic       o_SPI_MISO
);
    localparam logic CPOL = SPI_MODE[1];
    localparam logic CPHA = SPI_MODE[0];

    typedef enum logic {IDLE, ACTIVE} state_t;

    state_t     state_q, state_d;
    logic [1:0] sclk_sync_q, sclk_sync_d, cs_sync_q, cs_sync_d, mosi_sync_q, mosi_sync_d;
    logic       sclk_prev_q, sclk_prev_d, cs_prev_q, cs_prev_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] rx_shift_q, rx_shift_d, rx_byte_q, rx_byte_d;
    logic       rx_dv_q, rx_dv_d;
    logic [7:0] tx_shift_q, tx_shift_d, hold_q, hold_d;
    logic       hold_vld_q, hold_vld_d, miso_q, miso_d;

    logic       sclk_rise, sclk_fall, lead, trail, sample, drive;
    logic       cs_fall, cs_rise, active, run, wrap, start, accept, shift_out;
    logic [7:0] next_byte;

    always_comb begin
        sclk_rise = sclk_sync_q[1] & ~sclk_prev_q;
        sclk_fall = ~sclk_sync_q[1] & sclk_prev_q;
        lead      = CPOL ? sclk_fall : sclk_rise;
        trail     = CPOL ? sclk_rise : sclk_fall;
        sample    = CPHA ? trail : lead;
        drive     = CPHA ? lead : trail;
        cs_fall   = ~cs_sync_q[1] & cs_prev_q;
        cs_rise   = cs_sync_q[1] & ~cs_prev_q;
        active    = state_q == ACTIVE;
        // A CS_n rising edge wins over any SCLK edge seen in the same cycle.
        run       = active & ~cs_rise;
        wrap      = run & sample & (bit_cnt_q == 3'd7);
        start     = (~active & cs_fall) | wrap;
        accept    = i_TX_DV & ~hold_vld_q;
        // Load-through: a byte accepted exactly at byte start goes straight to the shifter.
        next_byte = hold_vld_q ? hold_q : accept ? i_TX_Byte : DEFAULT_TX;
        // CPHA=0 already put bit 7 out at byte start, so the trailing edge right after the wrap must not shift.
        shift_out = run & drive & (CPHA | (|bit_cnt_q));
        sclk_sync_d = {sclk_sync_q[0], i_SPI_Clk};
        cs_sync_d   = {cs_sync_q[0], i_SPI_CS_n};
        mosi_sync_d = {mosi_sync_q[0], i_SPI_MOSI};
        sclk_prev_d = sclk_sync_q[1];
        cs_prev_d   = cs_sync_q[1];
        state_d     = cs_fall ? ACTIVE : cs_rise ? IDLE : state_q;
        bit_cnt_d   = ~run ? 3'd0 : sample ? bit_cnt_q + 3'd1 : bit_cnt_q;
        rx_shift_d  = ~run ? 8'h00 : sample ? {rx_shift_q[6:0], mosi_sync_q[1]} : rx_shift_q;
        rx_dv_d     = wrap;
        rx_byte_d   = wrap ? {rx_shift_q[6:0], mosi_sync_q[1]} : rx_byte_q;
        hold_vld_d  = start ? 1'b0 : accept ? 1'b1 : hold_vld_q;
        hold_d      = accept ? i_TX_Byte : hold_q;
        // CPHA=1 drives bit 7 on the first leading edge; CPHA=0 drives it immediately.
        tx_shift_d  = start ? (CPHA ? next_byte : {next_byte[6:0], 1'b0})
                    : shift_out ? {tx_shift_q[6:0], 1'b0} : run ? tx_shift_q : 8'h00;
        miso_d      = start ? (~CPHA & next_byte[7]) : shift_out ? tx_shift_q[7] : run & miso_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            sclk_sync_q <= '0;
            cs_sync_q   <= '0;
            mosi_sync_q <= '0;
            sclk_prev_q <= 1'b0;
            cs_prev_q   <= 1'b0;
            bit_cnt_q   <= '0;
            rx_shift_q  <= '0;
            rx_byte_q   <= '0;
            rx_dv_q     <= 1'b0;
            tx_shift_q  <= '0;
            hold_q      <= '0;
            hold_vld_q  <= 1'b0;
            miso_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            sclk_sync_q <= sclk_sync_d;
            cs_sync_q   <= cs_sync_d;
            mosi_sync_q <= mosi_sync_d;
            sclk_prev_q <= sclk_prev_d;
            cs_prev_q   <= cs_prev_d;
            bit_cnt_q   <= bit_cnt_d;
            rx_shift_q  <= rx_shift_d;
            rx_byte_q   <= rx_byte_d;
            rx_dv_q     <= rx_dv_d;
            tx_shift_q  <= tx_shift_d;
            hold_q      <= hold_d;
            hold_vld_q  <= hold_vld_d;
            miso_q      <= miso_d;
        end
    end

    assign o_TX_Ready = ~hold_vld_q;
    assign o_RX_DV    = rx_dv_q;
    assign o_RX_Byte  = rx_byte_q;
`ifdef SPI_SLAVE_MISO_TRISTATE_EN
    assign o_SPI_MISO = (state_q == ACTIVE) ? miso_q : 1'bz;
`else
    assign o_SPI_MISO = (state_q == ACTIVE) & miso_q;
`endif
endmodule

// File: doc/spi_slave.md
SPI_SLAVE -- requirements
Module: spi_slave

Interface
REQ-001 SHALL have parameter SPI_MODE, default 0, meaning CPOL = SPI_MODE[1] and CPHA = SPI_MODE[0], legal values 0..3.
REQ-002 SHALL have parameter DEFAULT_TX, default 8'h00, meaning the byte shifted out when no TX byte is pending.
REQ-003 SHALL have port clk  input  1  system clock; all logic is in one clock domain, rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port i_TX_Byte  input  8  byte to return to the master.
REQ-006 SHALL have port i_TX_DV  input  1  one-cycle strobe that loads i_TX_Byte.
REQ-007 SHALL have port o_TX_Ready  output  1  high when the TX holding register is empty.
REQ-008 SHALL have port o_RX_DV  output  1  one-cycle strobe: o_RX_Byte is valid.
REQ-009 SHALL have port o_RX_Byte  output  8  last complete byte received from the master.
REQ-010 SHALL have port i_SPI_Clk  input  1  SCLK from the master, asynchronous to clk.
REQ-011 SHALL have port i_SPI_CS_n  input  1  chip select, active-low, asynchronous.
REQ-012 SHALL have port i_SPI_MOSI  input  1  serial data from the master.
REQ-013 SHALL have port o_SPI_MISO  output  1  serial data to the master.

Function
REQ-014 SHALL pass i_SPI_Clk, i_SPI_CS_n and i_SPI_MOSI through 2-flop synchronizers and detect edges on the synchronized SCLK; legal SCLK half-period is >= 4 clk cycles.
REQ-015 SHALL implement two states:
  - IDLE, while synchronized CS_n is high.
  - ACTIVE, entered on the synchronized CS_n falling edge and left on its rising edge.
REQ-016 SHALL, in ACTIVE, sample MOSI into the RX shift register MSB-first on the sample edge:
  - Sample edge is the leading SCLK edge when CPHA=0 and the trailing edge when CPHA=1.
  - Leading edge is rising when CPOL=0 and falling when CPOL=1.
REQ-017 SHALL drive the next MISO bit, MSB-first, on the edge opposite to the sample edge.
REQ-018 SHALL, for CPHA=0, present TX bit 7 on MISO within 1 clk after entering ACTIVE.
REQ-019 SHALL keep a 3-bit bit counter that:
  - increments on every sample edge;
  - wraps 7 -> 0;
  - on wrap, copies the RX shift register to o_RX_Byte and pulses o_RX_DV high for exactly 1 clk, 1 clk after the 8th sample edge is detected.
REQ-020 SHALL move the TX holding register into the TX shift register at each byte start: entry to ACTIVE, and the bit-counter wrap while CS_n stays low; if the holding register is empty it SHALL load DEFAULT_TX.
REQ-021 SHALL load i_TX_Byte into the holding register when i_TX_DV=1 and o_TX_Ready=1, drop o_TX_Ready the next cycle, and ignore i_TX_DV while o_TX_Ready=0.
REQ-022 SHALL re-assert o_TX_Ready the cycle after the holding register is consumed at a byte start.
REQ-023 SHALL, if i_TX_DV with o_TX_Ready=1 coincides with a byte start, shift out the new byte (load-through) and leave the holding register empty.
REQ-024 SHALL, on a CS_n rising edge mid-byte:
  - clear the bit counter and discard the partial RX byte, with no o_RX_DV pulse;
  - discard the partial TX shift byte;
  - preserve the holding register.
REQ-025 SHALL support back-to-back bytes with CS_n held low, with no lost bits.
REQ-026 SHALL hold o_RX_Byte stable between o_RX_DV pulses.

Reset
REQ-027 SHALL, while rst=1, asynchronously clear the state to IDLE, the bit counter, both shift registers, the holding register and the synchronizers.
REQ-028 SHALL, while rst=1, drive o_RX_DV=0, o_RX_Byte=8'h00, o_TX_Ready=1 and o_SPI_MISO=0, or Z when SPI_SLAVE_MISO_TRISTATE_EN is defined.
REQ-029 SHALL, if rst asserts mid-transfer, produce no o_RX_DV, and SHALL start the first transfer after reset release on the next CS_n falling edge.

Configuration
REQ-030 SHALL, when macro SPI_SLAVE_MISO_TRISTATE_EN is defined, drive o_SPI_MISO to high-impedance whenever the state is IDLE or rst=1.
REQ-031 SHALL, when SPI_SLAVE_MISO_TRISTATE_EN is undefined, drive o_SPI_MISO to 0 in IDLE and in reset; all other behaviour is identical.

Verification
REQ-032 SHALL cover mode 0, SCLK = clk/4: preload 8'h3C, master sends 8'hA5 -> o_RX_Byte=8'hA5, one o_RX_DV pulse, master receives 8'h3C, o_TX_Ready re-asserts.
REQ-033 SHALL cover mode 0, CS_n held low, master sends 8'h12 then 8'h34, slave preloads 8'hC1 and loads 8'hC2 after o_TX_Ready -> two o_RX_DV pulses (8'h12, 8'h34), master receives 8'hC1, 8'hC2.
REQ-034 SHALL cover a transfer with no TX byte loaded -> master receives DEFAULT_TX (8'h00).
REQ-035 SHALL cover CS_n deasserted after 5 bits, then a full byte 8'h81 -> no o_RX_DV for the partial byte; next o_RX_DV carries 8'h81.
REQ-036 SHALL cover SPI_MODE=3 (and 1, 2): master sends 8'h5A, slave returns 8'hE7 -> both bytes correct.
REQ-037 SHALL cover rst pulsed after bit 4, then a new 8'h0F transfer -> all outputs at reset values during rst, no o_RX_DV, next o_RX_DV carries 8'h0F; MISO is Z in IDLE only when SPI_SLAVE_MISO_TRISTATE_EN is defined.
